// File: rtl/serial_tx_buffer.sv
// Parallel-in/serial-out transmit buffer: DEPTH-word FIFO feeding a shift register.
// Optional per-frame even parity bit when SERIAL_TX_PARITY_EN is defined.
module serial_tx_buffer #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  input  logic             ser_en,
  output logic             full,
  output logic             empty,
  output logic             dout,
  output logic             dvalid,
  output logic             sof,
  output logic             busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
`ifdef SERIAL_TX_PARITY_EN
  localparam int FW = WIDTH + 1;
`else
  localparam int FW = WIDTH;
`endif
  localparam int BW = $clog2(FW+1);

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count, count_n;
  logic [FW-1:0]    sreg, sreg_n, frame;
  logic [BW-1:0]    bit_cnt, bit_cnt_n;
  logic             dout_n, dvalid_n, sof_n, busy_n;
  logic             push, pop;

  // Full at the edge blocks the write even if a pop frees a slot at that same edge.
  assign push = load & ~full;

  // Frame is arranged so the first bit out sits at the shift end; parity trails the data.
  always_comb begin
`ifdef SERIAL_TX_PARITY_EN
    if (MSB_FIRST != 0) frame = {mem[rd_ptr], ^mem[rd_ptr]};
    else                frame = {^mem[rd_ptr], mem[rd_ptr]};
`else
    frame = mem[rd_ptr];
`endif
  end

  function automatic logic first_bit(input logic [FW-1:0] v);
    return (MSB_FIRST != 0) ? v[FW-1] : v[0];
  endfunction

  function automatic logic [FW-1:0] shifted(input logic [FW-1:0] v);
    return (MSB_FIRST != 0) ? {v[FW-2:0], 1'b0} : {1'b0, v[FW-1:1]};
  endfunction

  always_comb begin
    state_n   = state;
    sreg_n    = sreg;
    bit_cnt_n = bit_cnt;
    dout_n    = dout;
    dvalid_n  = 1'b0;
    sof_n     = 1'b0;
    busy_n    = busy;
    pop       = 1'b0;
    if (ser_en) begin
      if (state == SHIFT && bit_cnt != BW'(FW)) begin
        dout_n    = first_bit(sreg);
        sreg_n    = shifted(sreg);
        bit_cnt_n = bit_cnt + BW'(1);
        dvalid_n  = 1'b1;
      end else if (!empty) begin
        pop       = 1'b1;
        state_n   = SHIFT;
        dout_n    = first_bit(frame);
        sreg_n    = shifted(frame);
        bit_cnt_n = BW'(1);
        dvalid_n  = 1'b1;
        sof_n     = 1'b1;
        busy_n    = 1'b1;
      end else if (state == SHIFT) begin
        state_n = IDLE;
        dout_n  = 1'b0;
        busy_n  = 1'b0;
      end
    end
  end

  always_comb begin
    count_n = count;
    case ({push, pop})
      2'b10:   count_n = count + CW'(1);
      2'b01:   count_n = count - CW'(1);
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      sreg    <= '0;
      bit_cnt <= '0;
      dout    <= 1'b0;
      dvalid  <= 1'b0;
      sof     <= 1'b0;
      busy    <= 1'b0;
      full    <= 1'b0;
      empty   <= 1'b1;
    end else begin
      state   <= state_n;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count   <= count_n;
      sreg    <= sreg_n;
      bit_cnt <= bit_cnt_n;
      dout    <= dout_n;
      dvalid  <= dvalid_n;
      sof     <= sof_n;
      busy    <= busy_n;
      full    <= (count_n == CW'(DEPTH));
      empty   <= (count_n == '0);
    end
  end
endmodule

// File: tb/tb_serial_tx_buffer.sv
// Bench for serial_tx_buffer: MSB-first and LSB-first instances share stimulus and are
// checked every cycle against a queue-based model, plus a vector table and directed sequences.
module tb_serial_tx_buffer;
  localparam int W = 3;
  localparam int D = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int FW = W + 1;
`else
  localparam int FW = W;
`endif

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic [W-1:0] din = '0;
  logic load = 1'b0;
  logic ser_en = 1'b0;
  logic full0, empty0, dout0, dvalid0, sof0, busy0;
  logic full1, empty1, dout1, dvalid1, sof1, busy1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_tx_buffer #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rstN(rstN), .din(din), .load(load), .ser_en(ser_en),
    .full(full0), .empty(empty0), .dout(dout0), .dvalid(dvalid0), .sof(sof0), .busy(busy0));

  serial_tx_buffer #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rstN(rstN), .din(din), .load(load), .ser_en(ser_en),
    .full(full1), .empty(empty1), .dout(dout1), .dvalid(dvalid1), .sof(sof1), .busy(busy1));

  // Reference model: queued words plus the remaining bits of the frame on the line.
  logic [W-1:0] q[$];
  bit cur0[$], cur1[$];
  bit md0, md1, mv, ms, mb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete(); cur0.delete(); cur1.delete();
    md0 = 0; md1 = 0; mv = 0; ms = 0; mb = 0;
  endtask

  task automatic model_step(input bit l, input logic [W-1:0] d, input bit e);
    bit was_full;
    logic [W-1:0] w;
    was_full = (q.size() == D);
    if (e) begin
      if (cur0.size() > 0) begin
        md0 = cur0.pop_front(); md1 = cur1.pop_front(); mv = 1; ms = 0;
      end else if (q.size() > 0) begin
        w = q.pop_front();
        for (int i = W-1; i >= 0; i--) cur0.push_back(w[i]);
        for (int i = 0; i < W; i++)    cur1.push_back(w[i]);
`ifdef SERIAL_TX_PARITY_EN
        cur0.push_back(^w); cur1.push_back(^w);
`endif
        md0 = cur0.pop_front(); md1 = cur1.pop_front(); mv = 1; ms = 1; mb = 1;
      end else begin
        md0 = 0; md1 = 0; mv = 0; ms = 0; mb = 0;
      end
    end else begin
      mv = 0; ms = 0;
    end
    if (l && !was_full) q.push_back(d);
  endtask

  task automatic check_model();
    chk("dout_msb", dout0, md0);     chk("dout_lsb", dout1, md1);
    chk("dvalid_msb", dvalid0, mv);  chk("dvalid_lsb", dvalid1, mv);
    chk("sof_msb", sof0, ms);        chk("sof_lsb", sof1, ms);
    chk("busy_msb", busy0, mb);      chk("busy_lsb", busy1, mb);
    chk("full_msb", full0, q.size() == D);  chk("full_lsb", full1, q.size() == D);
    chk("empty_msb", empty0, q.size() == 0); chk("empty_lsb", empty1, q.size() == 0);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cyc(input bit l, input logic [W-1:0] d, input bit e);
    load = l; din = d; ser_en = e;
    @(posedge clk);
    model_step(l, d, e);
    @(negedge clk);
    check_model();
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_dout"}, {dout0, dout1}, 2'b00);
    chk({nm, "_dvalid"}, {dvalid0, dvalid1}, 2'b00);
    chk({nm, "_sof"}, {sof0, sof1}, 2'b00);
    chk({nm, "_busy"}, {busy0, busy1}, 2'b00);
    chk({nm, "_full"}, {full0, full1}, 2'b00);
    chk({nm, "_empty"}, {empty0, empty1}, 2'b11);
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock.
  task automatic async_rst();
    #2 rstN = 1'b0;
    #1 check_reset_outputs("arst");
    model_reset();
    @(negedge clk);
    rstN = 1'b1;
  endtask

  typedef struct {
    bit ld; logic [W-1:0] d; bit en;
    bit x_dout; bit x_dv; bit x_sof; bit x_busy; bit x_empty;
  } vec_t;
  vec_t tv[$];

  logic [15:0] stream;
  int nbits;

  initial begin
`ifdef SERIAL_TX_PARITY_EN
    // loads 101 then 111 -> 1,0,1,0 | 1,1,1,1
    tv.push_back('{1, 3'b101, 1, 0, 0, 0, 0, 0});
    tv.push_back('{1, 3'b111, 1, 1, 1, 1, 1, 0});
    tv.push_back('{0, 3'b000, 1, 0, 1, 0, 1, 0});
    tv.push_back('{0, 3'b000, 1, 1, 1, 0, 1, 0});
    tv.push_back('{0, 3'b000, 1, 0, 1, 0, 1, 0});
    tv.push_back('{0, 3'b000, 1, 1, 1, 1, 1, 1});
    tv.push_back('{0, 3'b000, 1, 1, 1, 0, 1, 1});
    tv.push_back('{0, 3'b000, 1, 1, 1, 0, 1, 1});
    tv.push_back('{0, 3'b000, 1, 1, 1, 0, 1, 1});
    tv.push_back('{0, 3'b000, 1, 0, 0, 0, 0, 1});
`else
    // single word 101, then back-to-back 101, 010
    tv.push_back('{1, 3'b101, 1, 0, 0, 0, 0, 0});
    tv.push_back('{0, 3'b000, 1, 1, 1, 1, 1, 1});
    tv.push_back('{0, 3'b000, 1, 0, 1, 0, 1, 1});
    tv.push_back('{0, 3'b000, 1, 1, 1, 0, 1, 1});
    tv.push_back('{0, 3'b000, 1, 0, 0, 0, 0, 1});
    tv.push_back('{1, 3'b101, 1, 0, 0, 0, 0, 0});
    tv.push_back('{1, 3'b010, 1, 1, 1, 1, 1, 0});
    tv.push_back('{0, 3'b000, 1, 0, 1, 0, 1, 0});
    tv.push_back('{0, 3'b000, 1, 1, 1, 0, 1, 0});
    tv.push_back('{0, 3'b000, 1, 0, 1, 1, 1, 1});
    tv.push_back('{0, 3'b000, 1, 1, 1, 0, 1, 1});
    tv.push_back('{0, 3'b000, 1, 0, 1, 0, 1, 1});
    tv.push_back('{0, 3'b000, 1, 0, 0, 0, 0, 1});
`endif
    model_reset();
    @(negedge clk);
    check_reset_outputs("rst");
    rstN = 1'b1;

    foreach (tv[i]) begin
      cyc(tv[i].ld, tv[i].d, tv[i].en);
      chk("tv_dout", dout0, tv[i].x_dout);
      chk("tv_dvalid", dvalid0, tv[i].x_dv);
      chk("tv_sof", sof0, tv[i].x_sof);
      chk("tv_busy", busy0, tv[i].x_busy);
      chk("tv_empty", empty0, tv[i].x_empty);
    end

    // Fill while stalled, overflow load dropped, then drain.
    async_rst();
    cyc(1, 3'd1, 0); cyc(1, 3'd2, 0); cyc(1, 3'd3, 0);
    chk("fill3_full", full0, 1'b0);
    cyc(1, 3'd4, 0);
    chk("fill4_full", full0, 1'b1);
    cyc(1, 3'd7, 0);
    chk("drop_full", full0, 1'b1);
    stream = '0; nbits = 0;
    for (int i = 0; i < 4*FW + 3; i++) begin
      cyc(0, '0, 1);
      if (dvalid0) begin stream = {stream[14:0], dout0}; nbits++; end
    end
`ifdef SERIAL_TX_PARITY_EN
    chk("drain_stream", stream, 16'b0011_0101_0110_1001);
`else
    chk("drain_stream", stream, 16'b0000_001_010_011_100);
`endif
    chk("drain_nbits", nbits, 4*FW);
    chk("drain_empty", empty0, 1'b1);

    // Stall for two cycles after the first bit.
    async_rst();
    nbits = 0;
    cyc(1, 3'b101, 1);
    cyc(0, '0, 1); nbits += int'(dvalid0);
    chk("stall_first", {dout0, sof0}, 2'b11);
    for (int i = 0; i < 2; i++) begin
      cyc(0, '0, 0); nbits += int'(dvalid0);
      chk("stall_hold", {dout0, dvalid0, busy0}, 3'b101);
    end
    cyc(0, '0, 1); nbits += int'(dvalid0);
    chk("resume_b1", {dout0, dvalid0}, 2'b01);
    cyc(0, '0, 1); nbits += int'(dvalid0);
    chk("resume_b2", {dout0, dvalid0}, 2'b11);
    for (int i = 0; i < 3; i++) begin cyc(0, '0, 1); nbits += int'(dvalid0); end
    chk("stall_nbits", nbits, FW);

    // LSB-first order, then reset in the middle of the word.
    async_rst();
    cyc(1, 3'b110, 1);
    cyc(0, '0, 1);
    chk("lsb_b0", {dout1, dvalid1, sof1}, 3'b011);
    cyc(0, '0, 1);
    chk("lsb_b1", {dout1, dvalid1}, 2'b11);
    async_rst();
    nbits = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(0, '0, 1);
      nbits += int'(dvalid0) + int'(dvalid1);
    end
    chk("post_rst_bits", nbits, 0);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) async_rst();
      cyc(1'($urandom_range(0, 1)), W'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
